// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready and flush
// Levels run MSB-first; a register stage closes every REG_EVERY levels and after the last level.
module barrel_shift_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4,
  localparam int LOG2W    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L = (LOG2W + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic advance;
  logic v_last;

  assign advance  = ~v_last | out_ready;
  assign in_ready = reset_n & advance & ~flush;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op, input int amt);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = $signed(d) >>> amt;
      default: r = (d << amt) | (d >> (WIDTH - amt));
    endcase
    return r;
  endfunction

  for (genvar s = 0; s < L; s++) begin : stage
    localparam int LO = s * REG_EVERY;
    localparam int HI = (LO + REG_EVERY > LOG2W) ? LOG2W : LO + REG_EVERY;
    // Only the shamt bits still to be consumed are carried forward.
    localparam int SW = LOG2W - LO;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [SW-1:0]    src_shamt;
    logic [1:0]       src_op;
    logic [TAG_W-1:0] src_tag;
    logic [WIDTH-1:0] res_data;

    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic [TAG_W-1:0] q_tag;

    if (s == 0) begin : g_src
      assign src_valid = in_valid & in_ready;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_op    = in_op;
      assign src_tag   = in_tag;
    end else begin : g_src
      assign src_valid = stage[s-1].q_valid;
      assign src_data  = stage[s-1].q_data;
      assign src_shamt = stage[s-1].g_ctl.q_shamt;
      assign src_op    = stage[s-1].g_ctl.q_op;
      assign src_tag   = stage[s-1].q_tag;
    end

    always_comb begin
      res_data = src_data;
      for (int j = LO; j < HI; j++) begin
        if (src_shamt[LOG2W-1-j]) res_data = shift_level(res_data, src_op, 1 << (LOG2W - 1 - j));
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_valid <= 1'b0;
        q_data  <= '0;
        q_tag   <= '0;
      end else if (flush) begin
        q_valid <= 1'b0;
      end else if (advance) begin
        q_valid <= src_valid;
        q_data  <= res_data;
        q_tag   <= src_tag;
      end
    end

    if (s < L - 1) begin : g_ctl
      localparam int RW = LOG2W - HI;
      logic [RW-1:0] q_shamt;
      logic [1:0]    q_op;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q_shamt <= '0;
          q_op    <= '0;
        end else if (!flush && advance) begin
          q_shamt <= src_shamt[RW-1:0];
          q_op    <= src_op;
        end
      end
    end
  end

  assign v_last    = stage[L-1].q_valid;
  assign out_valid = v_last;
  assign out_data  = stage[L-1].q_data;
  assign out_tag   = stage[L-1].q_tag;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - self-checking bench for barrel_shift_pipe
module tb_barrel_shift_pipe;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  barrel_shift_pipe #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] d; logic [3:0] t; } exp_t;
  typedef struct { logic [1:0] op; logic [31:0] d; logic [4:0] sh; logic [31:0] res; } vec_t;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [3:0]  pop_tags[$];
  logic        last_acc = 1'b0;
  logic        stall_pending = 1'b0;
  logic [31:0] stall_data;
  logic [3:0]  stall_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain wide arithmetic, independent of the level structure.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
    logic [63:0] w;
    case (op)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: begin w = {{32{d[31]}}, d}; w = w >> s; return w[31:0]; end
      default: begin w = {d, d}; w = w << s; return w[63:32]; end
    endcase
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    last_acc = in_valid & in_ready;
    chk("in_ready", 64'(in_ready), 64'(reset_n & (~out_valid | out_ready) & ~flush));
    if (stall_pending) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", 64'(out_data), 64'(stall_data));
      chk("stall_tag", 64'(out_tag), 64'(stall_tag));
    end
    stall_pending = out_valid & ~out_ready & ~flush;
    stall_data = out_data;
    stall_tag = out_tag;
    if (out_valid && out_ready) begin
      pop_tags.push_back(out_tag);
      if (exp_q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_tag", 64'(out_tag), 64'(e.t));
      end
    end
    if (flush) exp_q.delete();
    if (last_acc) exp_q.push_back('{ref_shift(in_data, in_shamt, in_op), in_tag});
    @(posedge clock);
    #1;
  endtask

  task automatic issue_wait(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                            input logic [3:0] tg, output int lat, output logic [31:0] rd,
                            output logic [3:0] rt);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg;
    out_ready = 1'b1; flush = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    if (!last_acc) chk("accept_timeout", 64'(0), 64'(1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd = out_data;
    rt = out_tag;
    tick();
  endtask

  vec_t        vt[12];
  int          lat;
  logic [31:0] rd;
  logic [3:0]  rt;
  logic [3:0]  tg;

  initial begin
    vt[0]  = '{2'd0, 32'h0000FFFF, 5'd16, 32'hFFFF0000};
    vt[1]  = '{2'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF};
    vt[2]  = '{2'd1, 32'h80000000, 5'd31, 32'h00000001};
    vt[3]  = '{2'd0, 32'h80000000, 5'd31, 32'h00000000};
    vt[4]  = '{2'd3, 32'h80000001, 5'd1,  32'h00000003};
    vt[5]  = '{2'd0, 32'hA5A55A5A, 5'd0,  32'hA5A55A5A};
    vt[6]  = '{2'd1, 32'hA5A55A5A, 5'd0,  32'hA5A55A5A};
    vt[7]  = '{2'd2, 32'hA5A55A5A, 5'd0,  32'hA5A55A5A};
    vt[8]  = '{2'd3, 32'hA5A55A5A, 5'd0,  32'hA5A55A5A};
    vt[9]  = '{2'd2, 32'h7FFFFFFF, 5'd4,  32'h07FFFFFF};
    vt[10] = '{2'd3, 32'h12345678, 5'd4,  32'h23456781};
    vt[11] = '{2'd2, 32'hF0000000, 5'd3,  32'hFE000000};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue_wait(vt[i].op, vt[i].d, vt[i].sh, 4'(i), lat, rd, rt);
      chk($sformatf("vec%0d_data", i), 64'(rd), 64'(vt[i].res));
      chk($sformatf("vec%0d_tag", i), 64'(rt), 64'(i));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(5));
    end

    // Back-to-back issue under a toggling consumer.
    pop_tags.delete();
    tg = 4'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      in_valid = (tg < 4'd8);
      in_tag = tg; in_data = $urandom(); in_shamt = 5'($urandom_range(0, 31));
      in_op = 2'($urandom_range(0, 3));
      tick();
      if (last_acc) tg++;
      out_ready = ~out_ready;
      if (tg == 4'd8 && exp_q.size() == 0 && !out_valid) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t4_pop_count", 64'(pop_tags.size()), 64'(8));
    for (int i = 0; i < 8 && i < pop_tags.size(); i++)
      chk($sformatf("t4_order%0d", i), 64'(pop_tags[i]), 64'(i));

    // Flush with three in flight and a fourth presented in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = 4'(i); in_data = $urandom(); in_shamt = 5'(i); in_op = 2'd0;
      tick();
    end
    flush = 1'b1; in_tag = 4'd3;
    tick();
    chk("t5_flush_accept", 64'(last_acc), 64'(0));
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_no_out_valid", 64'(out_valid), 64'(0));
      tick();
    end
    issue_wait(2'd1, 32'hDEADBEEF, 5'd8, 4'd5, lat, rd, rt);
    chk("t5_data", 64'(rd), 64'(32'h00DEADBE));
    chk("t5_latency", 64'(lat), 64'(5));

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_tag = 4'(i); in_data = 32'hFFFFFFFF; in_shamt = 5'd0; in_op = 2'd3;
      tick();
    end
    chk("t6_pre_valid", 64'(out_valid), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_out_data", 64'(out_data), 64'(0));
    chk("t6_out_tag", 64'(out_tag), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete(); stall_pending = 1'b0; in_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    issue_wait(2'd0, 32'h00000001, 5'd31, 4'd9, lat, rd, rt);
    chk("t6_data", 64'(rd), 64'(32'h80000000));
    chk("t6_tag", 64'(rt), 64'(9));
    chk("t6_latency", 64'(lat), 64'(5));

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      in_data = $urandom(); in_shamt = 5'($urandom_range(0, 31));
      in_op = 2'($urandom_range(0, 3)); in_tag = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_out_valid", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
